uc_multicycle: RTL and testbench

UC_MULTICYCLE -- requirements
Module: uc_multicycle

---
 rtl/uc_multicycle.sv | 241 ++++++++++++++++++++++++
 tb/tb_uc_multicycle.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multicycle.sv
// Multicycle control unit: sequences fetch/decode/exec/mem/wb for an RV32I-style
// datapath, with sticky traps for illegal opcodes and memory timeouts.
module uc_multicycle #(
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter bit          JALR_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic             i_br_taken,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic [1:0]       o_pc_src,
  output logic             o_reg_write,
  output logic [1:0]       o_wb_sel,
  output logic             o_alu_src_a,
  output logic             o_alu_src_b,
  output logic [2:0]       o_imm_sel,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instret,
  output logic [2:0]       o_state
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Last count value before the wait limit of 2^TO_W-1 cycles is reached.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_opcode_q;
  logic [TO_W-1:0]  r_to;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instret;

  logic w_legal;
  logic w_wait;
  logic w_to_hit;
  logic w_set_ill;
  logic w_set_berr;
  logic w_is_load;
  logic w_is_store;
  logic w_is_lui;
  logic w_is_branch;
  logic w_is_jal;
  logic w_is_jalr;

  assign w_is_load   = (r_opcode_q == OP_LOAD);
  assign w_is_store  = (r_opcode_q == OP_STORE);
  assign w_is_lui    = (r_opcode_q == OP_LUI);
  assign w_is_branch = (r_opcode_q == OP_BRANCH);
  assign w_is_jal    = (r_opcode_q == OP_JAL);
  assign w_is_jalr   = (r_opcode_q == OP_JALR);
  assign w_to_hit    = (r_to == TO_LAST);

  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_bus_err = r_bus_err;
  assign o_instret = r_instret;

  // Legality check on the live opcode, used only in DECODE.
  always_comb begin
    w_legal = 1'b0;
    case (i_opcode)
      OP_IMM, OP_LOAD, OP_REG, OP_STORE,
      OP_LUI, OP_AUIPC, OP_JAL, OP_BRANCH: w_legal = 1'b1;
      OP_JALR:                             w_legal = JALR_EN;
      default:                             w_legal = 1'b0;
    endcase
  end

  // Next state and control outputs.
  always_comb begin
    w_next      = r_state;
    w_wait      = 1'b0;
    w_set_ill   = 1'b0;
    w_set_berr  = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_ir_write  = 1'b0;
    o_pc_write  = 1'b0;
    o_pc_src    = 2'b00;
    o_reg_write = 1'b0;
    o_wb_sel    = 2'b00;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 1'b0;
    o_imm_sel   = 3'b000;

    case (r_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          w_next     = S_DECODE;
        end else begin
          w_wait = 1'b1;
          if (w_to_hit) begin
            w_next     = S_TRAP;
            w_set_berr = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next    = S_TRAP;
          w_set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_branch) begin
          o_pc_write = 1'b1;
          o_pc_src   = i_br_taken ? 2'b01 : 2'b00;
          w_next     = S_FETCH;
        end else if (w_is_jal || w_is_jalr) begin
          o_reg_write = 1'b1;
          o_wb_sel    = 2'b10;
          o_pc_write  = 1'b1;
          o_pc_src    = w_is_jalr ? 2'b10 : 2'b01;
          w_next      = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = w_is_store;
        if (i_mem_ready) begin
          if (w_is_store) begin
            o_pc_write = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else begin
          w_wait = 1'b1;
          if (w_to_hit) begin
            w_next     = S_TRAP;
            w_set_berr = 1'b1;
          end
        end
      end
      S_WB: begin
        o_reg_write = 1'b1;
        o_wb_sel    = w_is_load ? 2'b01 : (w_is_lui ? 2'b11 : 2'b00);
        o_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase

    // Operand/immediate selects follow the latched opcode once past DECODE.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (r_opcode_q)
        OP_IMM, OP_LOAD, OP_JALR: o_alu_src_b = 1'b1;
        OP_STORE: begin
          o_imm_sel   = 3'b001;
          o_alu_src_b = 1'b1;
        end
        OP_LUI: begin
          o_imm_sel   = 3'b011;
          o_alu_src_b = 1'b1;
        end
        OP_AUIPC: begin
          o_imm_sel   = 3'b011;
          o_alu_src_a = 1'b1;
          o_alu_src_b = 1'b1;
        end
        OP_BRANCH: o_imm_sel = 3'b010;
        OP_JAL:    o_imm_sel = 3'b100;
        default:   o_imm_sel = 3'b000;
      endcase
    end

    // Reset silences every control output immediately.
    if (i_rst) begin
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_ir_write  = 1'b0;
      o_pc_write  = 1'b0;
      o_pc_src    = 2'b00;
      o_reg_write = 1'b0;
      o_wb_sel    = 2'b00;
      o_alu_src_a = 1'b0;
      o_alu_src_b = 1'b0;
      o_imm_sel   = 3'b000;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_opcode_q <= '0;
      r_to       <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode_q <= i_opcode;
      // Counter restarts on every state change, so it is zero on entry to FETCH/MEM.
      if (w_next != r_state) r_to <= '0;
      else if (w_wait)       r_to <= r_to + TO_W'(1);
      if (w_set_ill)  r_illegal <= 1'b1;
      if (w_set_berr) r_bus_err <= 1'b1;
      if (o_pc_write) r_instret <= r_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uc_multicycle.sv
// Bench for uc_multicycle: two configurations driven in parallel and checked every
// cycle against an instruction-level plan model, plus literal pinning checks.
module tb_uc_multicycle;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;

  logic       mem_req[2], mem_we[2], ir_write[2], pc_write[2], reg_write[2];
  logic       alu_a[2], alu_b[2], illegal[2], bus_err[2];
  logic [1:0] pc_src[2], wb_sel[2];
  logic [2:0] imm_sel[2], state[2];
  logic [31:0] instret0;
  logic [3:0]  instret1;

  uc_multicycle #(.TO_W(4), .CNT_W(32), .JALR_EN(1'b1)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_opcode(opcode), .i_br_taken(br_taken),
    .i_mem_ready(mem_ready), .o_mem_req(mem_req[0]), .o_mem_we(mem_we[0]),
    .o_ir_write(ir_write[0]), .o_pc_write(pc_write[0]), .o_pc_src(pc_src[0]),
    .o_reg_write(reg_write[0]), .o_wb_sel(wb_sel[0]), .o_alu_src_a(alu_a[0]),
    .o_alu_src_b(alu_b[0]), .o_imm_sel(imm_sel[0]), .o_illegal(illegal[0]),
    .o_bus_err(bus_err[0]), .o_instret(instret0), .o_state(state[0])
  );

  uc_multicycle #(.TO_W(2), .CNT_W(4), .JALR_EN(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_opcode(opcode), .i_br_taken(br_taken),
    .i_mem_ready(mem_ready), .o_mem_req(mem_req[1]), .o_mem_we(mem_we[1]),
    .o_ir_write(ir_write[1]), .o_pc_write(pc_write[1]), .o_pc_src(pc_src[1]),
    .o_reg_write(reg_write[1]), .o_wb_sel(wb_sel[1]), .o_alu_src_a(alu_a[1]),
    .o_alu_src_b(alu_b[1]), .o_imm_sel(imm_sel[1]), .o_illegal(illegal[1]),
    .o_bus_err(bus_err[1]), .o_instret(instret1), .o_state(state[1])
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] BR = 7'b1100011, JALR = 7'b1100111, BAD = 7'b1111111;

  // Per-instruction description: which phases it walks through and what it writes.
  typedef struct packed {
    logic       legal;
    logic [2:0] imm;
    logic       a;
    logic       b;
    logic       wr_rd;
    logic       store;
    logic       is_br;
    logic [1:0] wb;
    logic [1:0] src;
    logic [1:0] nph;
    logic [2:0] ph0;
    logic [2:0] ph1;
    logic [2:0] ph2;
  } info_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          m_st[2], m_pos[2], m_wait[2], m_trapcyc[2];
  logic [6:0]  m_opq[2];
  logic        m_ill[2], m_berr[2];
  logic [31:0] m_inst[2];

  function automatic info_t info(input logic [6:0] op, input bit je);
    info_t f;
    f = '0;
    f.legal = 1'b1;
    case (op)
      R:     begin f.wr_rd = 1; f.nph = 2; f.ph0 = 2; f.ph1 = 4; end
      I:     begin f.b = 1; f.wr_rd = 1; f.nph = 2; f.ph0 = 2; f.ph1 = 4; end
      LD:    begin f.b = 1; f.wr_rd = 1; f.wb = 1; f.nph = 3; f.ph0 = 2; f.ph1 = 3; f.ph2 = 4; end
      ST:    begin f.imm = 1; f.b = 1; f.store = 1; f.nph = 2; f.ph0 = 2; f.ph1 = 3; end
      LUI:   begin f.imm = 3; f.b = 1; f.wr_rd = 1; f.wb = 3; f.nph = 2; f.ph0 = 2; f.ph1 = 4; end
      AUIPC: begin f.imm = 3; f.a = 1; f.b = 1; f.wr_rd = 1; f.nph = 2; f.ph0 = 2; f.ph1 = 4; end
      JAL:   begin f.imm = 4; f.wr_rd = 1; f.wb = 2; f.src = 1; f.nph = 1; f.ph0 = 2; end
      BR:    begin f.imm = 2; f.is_br = 1; f.nph = 1; f.ph0 = 2; end
      JALR:  begin
        if (je) begin f.b = 1; f.wr_rd = 1; f.wb = 2; f.src = 2; f.nph = 1; f.ph0 = 2; end
        else f.legal = 1'b0;
      end
      default: f.legal = 1'b0;
    endcase
    return f;
  endfunction

  function automatic int ph_at(input info_t f, input int i);
    if (i == 0) return int'(f.ph0);
    if (i == 1) return int'(f.ph1);
    return int'(f.ph2);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_cycle(input int k);
    info_t       f;
    bit          wph, last, inexe;
    int          lim;
    logic [31:0] mask, act_inst;
    logic [2:0]  e_imm;
    logic [1:0]  e_src, e_wb;
    bit          e_req, e_we, e_ir, e_pcw, e_rw, e_a, e_b;
    lim      = (k == 0) ? 15 : 3;
    mask     = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    act_inst = (k == 0) ? instret0 : 32'(instret1);
    e_imm = '0; e_src = '0; e_wb = '0;
    e_req = 0; e_we = 0; e_ir = 0; e_pcw = 0; e_rw = 0; e_a = 0; e_b = 0;
    if (rst[k]) begin
      m_st[k] = 0; m_pos[k] = 0; m_wait[k] = 0; m_trapcyc[k] = 0;
      m_opq[k] = '0; m_ill[k] = 0; m_berr[k] = 0; m_inst[k] = '0;
    end else begin
      f     = info(m_opq[k], k == 0);
      wph   = (m_st[k] == 0) || (m_st[k] == 3);
      inexe = (m_st[k] >= 2) && (m_st[k] <= 4);
      last  = inexe && (m_pos[k] == int'(f.nph) - 1) && (!wph || mem_ready);
      e_req = wph;
      e_we  = (m_st[k] == 3) && f.store;
      e_ir  = (m_st[k] == 0) && mem_ready;
      e_pcw = last;
      e_src = !last ? 2'b00 : (f.is_br ? {1'b0, br_taken} : f.src);
      e_rw  = last && f.wr_rd;
      e_wb  = e_rw ? f.wb : 2'b00;
      if (inexe) begin e_imm = f.imm; e_a = f.a; e_b = f.b; end
    end
    chk("state", k, 32'(state[k]), 32'(m_st[k]));
    chk("mem_req", k, 32'(mem_req[k]), 32'(e_req));
    chk("mem_we", k, 32'(mem_we[k]), 32'(e_we));
    chk("ir_write", k, 32'(ir_write[k]), 32'(e_ir));
    chk("pc_write", k, 32'(pc_write[k]), 32'(e_pcw));
    chk("pc_src", k, 32'(pc_src[k]), 32'(e_src));
    chk("reg_write", k, 32'(reg_write[k]), 32'(e_rw));
    chk("wb_sel", k, 32'(wb_sel[k]), 32'(e_wb));
    chk("alu_src_a", k, 32'(alu_a[k]), 32'(e_a));
    chk("alu_src_b", k, 32'(alu_b[k]), 32'(e_b));
    chk("imm_sel", k, 32'(imm_sel[k]), 32'(e_imm));
    chk("illegal", k, 32'(illegal[k]), 32'(m_ill[k]));
    chk("bus_err", k, 32'(bus_err[k]), 32'(m_berr[k]));
    chk("instret", k, act_inst, m_inst[k]);
    if (rst[k]) return;
    // Advance the model across the coming clock edge.
    if (m_st[k] == 5) begin
      m_trapcyc[k]++;
    end else if (wph && !mem_ready) begin
      m_wait[k]++;
      if (m_wait[k] == lim) begin m_st[k] = 5; m_berr[k] = 1; end
    end else begin
      m_wait[k] = 0;
      if (m_st[k] == 0) begin
        m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        m_opq[k] = opcode;
        f = info(opcode, k == 0);
        if (f.legal) begin m_pos[k] = 0; m_st[k] = int'(f.ph0); end
        else begin m_st[k] = 5; m_ill[k] = 1; end
      end else if (last) begin
        m_inst[k] = (m_inst[k] + 32'd1) & mask;
        m_st[k]   = 0;
      end else begin
        m_pos[k]++;
        m_st[k] = ph_at(f, m_pos[k]);
      end
    end
  endtask

  task automatic cycle(input logic [1:0] r, input logic [6:0] op, input logic br, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; opcode = op; br_taken = br; mem_ready = rdy;
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
  endtask

  logic [6:0] ops[9];
  logic [1:0] rr;
  logic [6:0] rop;
  logic       rrdy;
  int         burst;

  initial begin
    ops = '{R, I, LD, ST, LUI, AUIPC, JAL, BR, JALR};
    rst = 2'b11; opcode = R; br_taken = 0; mem_ready = 1;

    // Reset, then one R-type with memory always ready.
    cycle(2'b11, R, 0, 1);
    chk("lit_rst_state", 0, 32'(state[0]), 0);
    chk("lit_rst_req", 0, 32'(mem_req[0]), 0);
    cycle(2'b11, R, 0, 1);
    cycle(2'b00, R, 0, 1);
    chk("lit_fetch_req", 0, 32'(mem_req[0]), 1);
    chk("lit_fetch_irw", 0, 32'(ir_write[0]), 1);
    cycle(2'b00, R, 0, 1);  chk("lit_decode", 0, 32'(state[0]), 1);
    cycle(2'b00, R, 0, 1);  chk("lit_exec", 0, 32'(state[0]), 2);
    cycle(2'b00, R, 0, 1);
    chk("lit_wb", 0, 32'(state[0]), 4);
    chk("lit_wb_rw", 0, 32'(reg_write[0]), 1);

    // Load with three MEM wait cycles (dut1 times out on the third).
    cycle(2'b00, LD, 0, 1); chk("lit_instret1", 0, instret0, 1);
    cycle(2'b00, LD, 0, 1);
    cycle(2'b00, LD, 0, 1); chk("lit_ld_b", 0, 32'(alu_b[0]), 1);
    cycle(2'b00, LD, 0, 0); chk("lit_mem1", 0, 32'(state[0]), 3);
    cycle(2'b00, LD, 0, 0);
    cycle(2'b00, LD, 0, 0);
    cycle(2'b00, LD, 0, 1);
    chk("lit_mem4", 0, 32'(state[0]), 3);
    chk("lit_to_trap", 1, 32'(state[1]), 5);
    chk("lit_to_berr", 1, 32'(bus_err[1]), 1);
    cycle(2'b00, BR, 1, 1); chk("lit_ld_wb", 0, 32'(wb_sel[0]), 1);

    // Branch taken, then not taken.
    cycle(2'b00, BR, 1, 1); chk("lit_instret2", 0, instret0, 2);
    cycle(2'b00, BR, 1, 1);
    cycle(2'b00, BR, 1, 1);
    chk("lit_br_taken", 0, 32'(pc_src[0]), 1);
    chk("lit_br_rw", 0, 32'(reg_write[0]), 0);
    cycle(2'b00, BR, 0, 1);
    cycle(2'b00, BR, 0, 1);
    cycle(2'b00, BR, 0, 1);
    chk("lit_br_not", 0, 32'(pc_src[0]), 0);
    chk("lit_br_pcw", 0, 32'(pc_write[0]), 1);

    // Illegal opcode traps and sticks.
    cycle(2'b00, BAD, 0, 1);
    cycle(2'b00, BAD, 0, 1);
    cycle(2'b00, R, 0, 1);
    chk("lit_ill_state", 0, 32'(state[0]), 5);
    chk("lit_ill_flag", 0, 32'(illegal[0]), 1);
    for (int i = 0; i < 3; i++) cycle(2'b00, R, 0, 1);
    chk("lit_ill_stuck", 0, 32'(state[0]), 5);
    chk("lit_ill_instret", 0, instret0, 4);

    // jalr: legal on dut0, illegal on dut1.
    cycle(2'b11, JALR, 0, 1);
    cycle(2'b00, JALR, 0, 1);
    cycle(2'b00, JALR, 0, 1);
    cycle(2'b00, R, 0, 1);
    chk("lit_jalr_src", 0, 32'(pc_src[0]), 2);
    chk("lit_jalr_wb", 0, 32'(wb_sel[0]), 2);
    chk("lit_jalr_ill", 1, 32'(illegal[1]), 1);

    // FETCH timeout on dut1, then ready arriving on the limit cycle.
    cycle(2'b11, R, 0, 0);
    for (int i = 0; i < 3; i++) cycle(2'b00, R, 0, 0);
    cycle(2'b00, R, 0, 0);
    chk("lit_fto_state", 1, 32'(state[1]), 5);
    chk("lit_fto_berr", 1, 32'(bus_err[1]), 1);
    chk("lit_fto_dut0", 0, 32'(state[0]), 0);
    cycle(2'b11, R, 0, 0);
    cycle(2'b00, R, 0, 0);
    cycle(2'b00, R, 0, 0);
    cycle(2'b00, R, 0, 1);
    cycle(2'b00, R, 0, 1);
    chk("lit_fto_win", 1, 32'(state[1]), 1);
    chk("lit_fto_noerr", 1, 32'(bus_err[1]), 0);

    // Reset in the middle of a stalled store.
    cycle(2'b11, R, 0, 1);
    for (int i = 0; i < 4; i++) cycle(2'b00, R, 0, 1);
    cycle(2'b00, ST, 0, 1);
    cycle(2'b00, ST, 0, 1);
    cycle(2'b00, ST, 0, 1);
    cycle(2'b00, ST, 0, 0);
    chk("lit_st_we", 0, 32'(mem_we[0]), 1);
    chk("lit_st_inst", 0, instret0, 1);
    cycle(2'b11, ST, 0, 0);
    chk("lit_st_rst_req", 0, 32'(mem_req[0]), 0);
    chk("lit_st_rst_we", 0, 32'(mem_we[0]), 0);
    chk("lit_st_rst_inst", 0, instret0, 0);
    cycle(2'b00, ST, 0, 1);
    chk("lit_st_rel", 0, 32'(state[0]), 0);
    chk("lit_st_rel_req", 0, 32'(mem_req[0]), 1);

    // Randomized traffic with stall bursts and occasional resets.
    burst = 0;
    for (int i = 0; i < 5000; i++) begin
      rr = 2'b00;
      for (int k = 0; k < 2; k++)
        if ((m_st[k] == 5 && m_trapcyc[k] >= 3) || $urandom_range(0, 299) == 0) rr[k] = 1'b1;
      if ($urandom_range(0, 19) == 0) rop = 7'($urandom);
      else rop = ops[$urandom_range(0, 8)];
      if (burst > 0) begin
        rrdy = 1'b0;
        burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        burst = $urandom_range(2, 17);
        rrdy  = 1'b0;
      end else begin
        rrdy = ($urandom_range(0, 3) != 0);
      end
      cycle(rr, rop, 1'($urandom), rrdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
